// File: rtl/exec_pkg.sv
// Shared types and bufferOut field offsets for the execute stage.
// Optional iterative multiplier is enabled with the EXEC_MUL_EN macro.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_SUB = 4'd0,
    ALU_ADD = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_CMP = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_MUL = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM    = 2'b01,
    FWD_WB     = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned DEF_N  = 24;
  localparam int unsigned DEF_RA = 4;

  // bufferOut field positions, LSB upwards: rd3, Rc, regWrite, memToReg,
  // memWrite, branchFlag, neg, zero, aluResult, opCode, opType.
  function automatic int unsigned rc_lsb(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned regwrite_bit(input int unsigned n, input int unsigned ra);
    return n + ra;
  endfunction

  function automatic int unsigned neg_bit(input int unsigned n, input int unsigned ra);
    return n + ra + 4;
  endfunction

  function automatic int unsigned zero_bit(input int unsigned n, input int unsigned ra);
    return n + ra + 5;
  endfunction

  function automatic int unsigned res_lsb(input int unsigned n, input int unsigned ra);
    return n + ra + 6;
  endfunction

  function automatic int unsigned opcode_lsb(input int unsigned n, input int unsigned ra);
    return 2 * n + ra + 6;
  endfunction

  function automatic int unsigned optype_lsb(input int unsigned n, input int unsigned ra);
    return 2 * n + ra + 10;
  endfunction

  localparam int unsigned DEF_RES_LSB  = res_lsb(DEF_N, DEF_RA);
  localparam int unsigned DEF_ZERO_BIT = zero_bit(DEF_N, DEF_RA);
  localparam int unsigned DEF_NEG_BIT  = neg_bit(DEF_N, DEF_RA);

endpackage

// File: rtl/exec_stage_mc_alu.sv
// Combinational N-bit ALU for single-cycle ops 0-6 with zero/neg flags.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [N-1:0] res_o,
  output logic         zero_o,
  output logic         neg_o
);

  // Result select; unsupported op codes yield zero.
  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_SUB, ALU_CMP: res_o = a_i - b_i;
      ALU_ADD:          res_o = a_i + b_i;
      ALU_AND:          res_o = a_i & b_i;
      ALU_OR:           res_o = a_i | b_i;
      ALU_SHL:          res_o = a_i << b_i[4:0];
      ALU_SHR:          res_o = $signed(a_i) >>> b_i[4:0];
      default:          res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);
  assign neg_o  = res_o[N-1];

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage with integrated EX/MEM register.
// Define EXEC_MUL_EN to build the iterative signed multiplier (aluControl 7).
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter  int unsigned N  = 24,
  parameter  int unsigned RA = 4,
  localparam int unsigned BW = 2 * N + RA + 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [1:0]    opType,
  input  logic [3:0]    opCode,
  input  logic [3:0]    aluControl,
  input  logic          immSrc,
  input  logic          branchFlag,
  input  logic          memWrite,
  input  logic          memToReg,
  input  logic          regWrite,
  input  logic [RA-1:0] Rc,
  input  logic [N-1:0]  rd1,
  input  logic [N-1:0]  rd2,
  input  logic [N-1:0]  rd3,
  input  logic [N-1:0]  imm,
  input  logic [N-1:0]  pc,
  input  logic [1:0]    fwdA,
  input  logic [1:0]    fwdB,
  input  logic [N-1:0]  fwd_mem,
  input  logic [N-1:0]  fwd_wb,
  output logic          stall_out,
  output logic          out_valid,
  output logic [BW-1:0] bufferOut
);

  logic [N-1:0]  op_a, op_b, fwd_b_val, st_data, alu_res;
  logic          alu_zero, alu_neg, accept, rw_eff, stall;
  logic [BW-1:0] alu_word, buf_d, buf_q;
  logic          vld_d, vld_q;

  function automatic logic [N-1:0] fwd_pick(input logic [1:0] sel, input logic [N-1:0] rf,
                                            input logic [N-1:0] mem, input logic [N-1:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  // Operand selection: forwarding first, then PC / immediate overrides.
  always_comb begin
    op_a      = branchFlag ? pc : fwd_pick(fwdA, rd1, fwd_mem, fwd_wb);
    fwd_b_val = fwd_pick(fwdB, rd2, fwd_mem, fwd_wb);
    op_b      = immSrc ? imm : fwd_b_val;
    st_data   = fwd_pick(fwdB, rd3, fwd_mem, fwd_wb);
  end

  exec_alu #(.N(N)) u_alu (
    .a_i    (op_a),
    .b_i    (op_b),
    .op_i   (aluControl),
    .res_o  (alu_res),
    .zero_o (alu_zero),
    .neg_o  (alu_neg)
  );

  assign accept   = en && in_valid && !stall;
  assign rw_eff   = regWrite && (aluControl != ALU_CMP);
  assign alu_word = {opType, opCode, alu_res, alu_zero, alu_neg, branchFlag,
                     memWrite, memToReg, rw_eff, Rc, st_data};

`ifdef EXEC_MUL_EN
  localparam int unsigned CW       = $clog2(N);
  localparam int unsigned RES_LSB  = res_lsb(N, RA);
  localparam int unsigned ZERO_BIT = zero_bit(N, RA);
  localparam int unsigned NEG_BIT  = neg_bit(N, RA);

  mul_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [N-1:0]  acc_step, prod, a_mag, b_mag;
  logic          sign_q, sign_d, is_mul;
  logic [BW-1:0] pend_q, pend_d, mul_word;

  assign is_mul   = (aluControl == ALU_MUL);
  assign stall    = (state_q != MUL_IDLE);
  assign a_mag    = op_a[N-1] ? -op_a : op_a;
  assign b_mag    = op_b[N-1] ? -op_b : op_b;
  // cnt_q is the multiplier bit consumed this cycle; MUL_DONE consumes the
  // last bit and registers the result on the same edge.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = sign_q ? -acc_step : acc_step;

  // Completed product merged into the control fields captured at accept.
  always_comb begin
    mul_word                  = pend_q;
    mul_word[RES_LSB +: N]    = prod;
    mul_word[ZERO_BIT]        = (prod == '0);
    mul_word[NEG_BIT]         = prod[N-1];
  end

  // Multiplier FSM next-state: latch magnitudes, then one shift-add per cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    pend_d   = pend_q;
    case (state_q)
      MUL_IDLE: begin
        if (accept && is_mul) begin
          state_d  = MUL_BUSY;
          cnt_d    = '0;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          sign_d   = op_a[N-1] ^ op_b[N-1];
          pend_d   = alu_word;
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_d == CW'(N - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Multiplier state registers; en=0 holds everything mid-multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      pend_q   <= '0;
    end else if (flush) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      pend_q   <= pend_d;
    end
  end

  // Output word: finished product, a single-cycle op, or a bubble.
  always_comb begin
    buf_d = '0;
    vld_d = 1'b0;
    if (state_q == MUL_DONE) begin
      buf_d = mul_word;
      vld_d = 1'b1;
    end else if (accept && !is_mul) begin
      buf_d = alu_word;
      vld_d = 1'b1;
    end
  end
`else
  assign stall = 1'b0;

  // Output word: accepted op or a bubble.
  always_comb begin
    buf_d = '0;
    vld_d = 1'b0;
    if (accept) begin
      buf_d = alu_word;
      vld_d = 1'b1;
    end
  end
`endif

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buf_q <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      buf_q <= buf_d;
      vld_q <= vld_d;
    end
  end

  assign stall_out = stall;
  assign out_valid = vld_q;
  assign bufferOut = buf_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc (N=24, RA=4) with a cycle-level reference model.
module tb_exec_stage_mc;

  localparam int N = 24;
`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid;
  logic [1:0]  opType, fwdA, fwdB;
  logic [3:0]  opCode, aluControl;
  logic        immSrc, branchFlag, memWrite, memToReg, regWrite;
  logic [3:0]  Rc;
  logic [23:0] rd1, rd2, rd3, imm, pc, fwd_mem, fwd_wb;
  logic        stall_out, out_valid;
  logic [63:0] bufferOut;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_buf, pend_buf;
  logic        exp_vld, exp_stall;
  int          mul_left;
  int          stall_cnt;

  always #5 clk = ~clk;

  exec_stage_mc #(.N(24), .RA(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .opType(opType), .opCode(opCode), .aluControl(aluControl),
    .immSrc(immSrc), .branchFlag(branchFlag), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .Rc(Rc),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .imm(imm), .pc(pc),
    .fwdA(fwdA), .fwdB(fwdB), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .stall_out(stall_out), .out_valid(out_valid), .bufferOut(bufferOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pick(input logic [1:0] sel, input logic [23:0] rf);
    if (sel == 2'b01) return fwd_mem;
    if (sel == 2'b10) return fwd_wb;
    return rf;
  endfunction

  function automatic longint sext(input logic [23:0] v);
    return longint'(signed'(v));
  endfunction

  // Expected output word for the op currently on the inputs.
  function automatic logic [63:0] calc_word();
    logic [23:0] a, b, st, r;
    longint      sa, sb;
    int          s;
    logic        rw;
    a  = branchFlag ? pc : pick(fwdA, rd1);
    b  = immSrc ? imm : pick(fwdB, rd2);
    st = pick(fwdB, rd3);
    sa = sext(a);
    sb = sext(b);
    s  = int'(b[4:0]);
    rw = regWrite;
    case (aluControl)
      4'd0: r = 24'(sa - sb);
      4'd1: r = 24'(sa + sb);
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: begin r = 24'(sa - sb); rw = 1'b0; end
      4'd5: r = 24'(sa << s);
      4'd6: r = 24'(sa >>> s);
      4'd7: r = MUL_ON ? 24'(sa * sb) : 24'd0;
      default: r = 24'd0;
    endcase
    return {opType, opCode, r, (r == 24'd0), r[23], branchFlag, memWrite,
            memToReg, rw, Rc, st};
  endfunction

  // Reference behaviour for one clock edge, given the current inputs.
  task automatic model_edge();
    logic [63:0] w;
    if (rst || flush) begin
      exp_buf = '0; exp_vld = 1'b0; exp_stall = 1'b0; mul_left = 0;
    end else if (en) begin
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          exp_buf = pend_buf; exp_vld = 1'b1; exp_stall = 1'b0;
        end else begin
          exp_buf = '0; exp_vld = 1'b0;
        end
      end else if (in_valid) begin
        w = calc_word();
        if (MUL_ON && aluControl == 4'd7) begin
          pend_buf = w; mul_left = N; exp_buf = '0; exp_vld = 1'b0; exp_stall = 1'b1;
        end else begin
          exp_buf = w; exp_vld = 1'b1;
        end
      end else begin
        exp_buf = '0; exp_vld = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ":buf"}, bufferOut, exp_buf);
    check({tag, ":vld"}, 64'(out_valid), 64'(exp_vld));
    check({tag, ":stall"}, 64'(stall_out), 64'(exp_stall));
  endtask

  task automatic clear_inputs();
    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    opType = '0; opCode = '0; aluControl = '0; immSrc = 1'b0; branchFlag = 1'b0;
    memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0; Rc = '0;
    rd1 = '0; rd2 = '0; rd3 = '0; imm = '0; pc = '0;
    fwdA = '0; fwdB = '0; fwd_mem = '0; fwd_wb = '0;
  endtask

  task automatic rand_ops();
    in_valid   = ($urandom_range(0, 4) != 0);
    opType     = 2'($urandom);
    opCode     = 4'($urandom);
    aluControl = 4'($urandom_range(0, 15));
    immSrc     = 1'($urandom);
    branchFlag = ($urandom_range(0, 7) == 0);
    memWrite   = 1'($urandom);
    memToReg   = 1'($urandom);
    regWrite   = 1'($urandom);
    Rc         = 4'($urandom);
    rd1        = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 3)) : 24'($urandom);
    rd2        = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 3)) : 24'($urandom);
    rd3        = 24'($urandom);
    imm        = 24'($urandom);
    pc         = 24'($urandom);
    fwdA       = 2'($urandom);
    fwdB       = 2'($urandom);
    fwd_mem    = 24'($urandom);
    fwd_wb     = 24'($urandom);
  endtask

  initial begin
    exp_buf = '0; exp_vld = 1'b0; exp_stall = 1'b0; mul_left = 0; pend_buf = '0;
    clear_inputs();
    rst = 1'b1; en = 1'b0;
    step("reset");
    check("rst_buf", bufferOut, 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd1; rd1 = 24'd2; rd2 = 24'd2; Rc = 4'd3; opCode = 4'd1;
    step("add");
    check("add_res", 64'(bufferOut[57:34]), 64'd4);
    check("add_zero", 64'(bufferOut[33]), 64'd0);
    check("add_rc", 64'(bufferOut[27:24]), 64'd3);
    check("add_opc", 64'(bufferOut[61:58]), 64'd1);
    check("add_vld", 64'(out_valid), 64'd1);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd4; rd1 = 24'd3; rd2 = 24'd3; regWrite = 1'b1;
    step("cmp");
    check("cmp_res", 64'(bufferOut[57:34]), 64'd0);
    check("cmp_zero", 64'(bufferOut[33]), 64'd1);
    check("cmp_rw", 64'(bufferOut[28]), 64'd0);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd0; rd1 = 24'd2; rd2 = 24'd3;
    step("sub");
    check("sub_res", 64'(bufferOut[57:34]), 64'hFFFFFF);
    check("sub_neg", 64'(bufferOut[32]), 64'd1);
    check("sub_zero", 64'(bufferOut[33]), 64'd0);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd1; fwdA = 2'b01; fwd_mem = 24'd10; rd1 = 24'd99; rd2 = 24'd5;
    step("fwd_a");
    check("fwd_a_res", 64'(bufferOut[57:34]), 64'd15);
    fwdB = 2'b10; fwd_wb = 24'd7; rd3 = 24'd33;
    step("fwd_b");
    check("fwd_b_res", 64'(bufferOut[57:34]), 64'd17);
    check("fwd_b_st", 64'(bufferOut[23:0]), 64'd7);
    immSrc = 1'b1; imm = 24'd9;
    step("imm");
    check("imm_res", 64'(bufferOut[57:34]), 64'd19);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd5; rd1 = 24'd1; rd2 = 24'd5;
    step("shl");
    check("shl_res", 64'(bufferOut[57:34]), 64'd32);
    aluControl = 4'd6; rd1 = 24'h800000; rd2 = 24'd4;
    step("shr");
    check("shr_res", 64'(bufferOut[57:34]), 64'hF80000);
    aluControl = 4'd1; branchFlag = 1'b1; pc = 24'h100; rd1 = 24'd5; rd2 = 24'd4;
    step("branch");
    check("br_res", 64'(bufferOut[57:34]), 64'h104);
    check("br_flag", 64'(bufferOut[31]), 64'd1);

    clear_inputs(); in_valid = 1'b0; aluControl = 4'd1; rd1 = 24'd1; regWrite = 1'b1;
    step("bubble");
    check("bubble_vld", 64'(out_valid), 64'd0);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd1; rd1 = 24'd1; rd2 = 24'd1;
    step("pre_hold");
    aluControl = 4'd0; rd1 = 24'd9; en = 1'b0;
    step("hold");
    check("hold_res", 64'(bufferOut[57:34]), 64'd2);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd11; rd1 = 24'd5; rd2 = 24'd6;
    step("op11");
    check("op11_zero", 64'(bufferOut[33]), 64'd1);

`ifdef EXEC_MUL_EN
    clear_inputs(); in_valid = 1'b1; aluControl = 4'd7; rd1 = 24'd7; rd2 = 24'hFFFFFD; Rc = 4'd5;
    step("mul_acc");
    check("mul_stall_on", 64'(stall_out), 64'd1);
    clear_inputs(); in_valid = 1'b1; aluControl = 4'd1; rd1 = 24'd1; rd2 = 24'd1;
    stall_cnt = 0;
    for (int i = 0; i < 40 && stall_out; i++) begin
      stall_cnt++;
      step("mul_wait");
    end
    check("mul_stall_cycles", 64'(stall_cnt), 64'd24);
    check("mul_res", 64'(bufferOut[57:34]), 64'hFFFFEB);
    check("mul_neg", 64'(bufferOut[32]), 64'd1);
    check("mul_vld", 64'(out_valid), 64'd1);
    check("mul_rc", 64'(bufferOut[27:24]), 64'd5);
    step("held_add");
    check("held_res", 64'(bufferOut[57:34]), 64'd2);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd7; rd1 = 24'hFFFFFB; rd2 = 24'd6;
    step("mul_en_acc");
    in_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      en = 1'($urandom);
      step("mul_en");
    end
    en = 1'b1;

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd7; rd1 = 24'd3; rd2 = 24'd3;
    step("fl_acc");
    for (int i = 0; i < 9; i++) step("fl_busy");
    flush = 1'b1;
    step("flush");
    check("flush_vld", 64'(out_valid), 64'd0);
    check("flush_stall", 64'(stall_out), 64'd0);
    flush = 1'b0; aluControl = 4'd1;
    step("post_flush");
    check("post_flush_res", 64'(bufferOut[57:34]), 64'd6);

    clear_inputs(); in_valid = 1'b1; aluControl = 4'd7; rd1 = 24'd3; rd2 = 24'd3;
    step("rst_acc");
    for (int i = 0; i < 5; i++) step("rst_busy");
    rst = 1'b1;
    step("mid_rst");
    check("mid_rst_buf", bufferOut, 64'd0);
    check("mid_rst_stall", 64'(stall_out), 64'd0);
    rst = 1'b0;
`else
    clear_inputs(); in_valid = 1'b1; aluControl = 4'd7; rd1 = 24'd7; rd2 = 24'd3;
    step("op7");
    check("op7_res", 64'(bufferOut[57:34]), 64'd0);
    check("op7_zero", 64'(bufferOut[33]), 64'd1);
    check("op7_stall", 64'(stall_out), 64'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      rand_ops();
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
